// File: rtl/led_sync_tx.sv
// LED-sync uplink transmitter: snapshots a 16-bit LED word and streams a
// header/data/trailer frame. Optional on-change trigger: LED_SYNC_TX_ON_CHANGE_EN.
module led_sync_tx #(
  parameter int unsigned g_PERIOD = 32'd2504937,
  parameter logic [7:0]  g_HEADER = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_i,
  input  logic        gbt_link_ready,
  input  logic        send_req_i,
  input  logic [15:0] led_i,
  input  logic        tx_ready_i,
  output logic [15:0] tx_data_o,
  output logic        tx_valid_o,
  output logic        frame_active_o,
  output logic [7:0]  seq_o,
  output logic [15:0] frames_sent_o
);

  localparam int unsigned CNT_W = (g_PERIOD > 32'd2) ? $clog2(g_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(g_PERIOD - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DAT  = 2'd2,
    ST_TRL  = 2'd3
  } state_t;

  function automatic logic [7:0] frame_ck(input logic [7:0] hdr,
                                          input logic [7:0] seq,
                                          input logic [15:0] led);
    return hdr ^ seq ^ led[15:8] ^ led[7:0];
  endfunction

  state_t           state_r, next_state_s;
  logic             pending_r, pending_s;
  logic [CNT_W-1:0] period_cnt_r;
  logic [15:0]      led_hold_r, led_hold_s;
  logic [7:0]       seq_r;
  logic [15:0]      frames_sent_r;
  logic [15:0]      tx_data_r, tx_data_s;
  logic             tx_valid_r, tx_valid_s;
  logic             frame_active_r;
  logic             expire_s, start_s, abort_s, xfer_s, done_s, on_change_s;
  logic [7:0]       ck_s;

`ifdef LED_SYNC_TX_ON_CHANGE_EN
  logic [15:0]      last_sent_r;

  // Last transmitted LED word, committed only when a trailer is accepted
  always_ff @(posedge clock) begin
    if (reset) begin
      last_sent_r <= 16'h0000;
    end else if (done_s) begin
      last_sent_r <= led_hold_r;
    end else begin
      last_sent_r <= last_sent_r;
    end
  end

  assign on_change_s = (state_r == ST_IDLE) && (led_i != last_sent_r);
`else
  assign on_change_s = 1'b0;
`endif

  // Frame control: request merging, state transitions and next output word
  always_comb begin
    expire_s     = (period_cnt_r == {CNT_W{1'b0}});
    start_s      = (state_r == ST_IDLE) && pending_r && enable_i && gbt_link_ready;
    abort_s      = (state_r != ST_IDLE) && !gbt_link_ready;
    xfer_s       = tx_valid_r && tx_ready_i && gbt_link_ready;
    done_s       = xfer_s && (state_r == ST_TRL);
    next_state_s = state_r;
    led_hold_s   = led_hold_r;
    ck_s         = frame_ck(g_HEADER, seq_r, led_hold_r);
    tx_data_s    = 16'h0000;
    tx_valid_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          next_state_s = ST_HDR;
          led_hold_s   = led_i;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (abort_s)     next_state_s = ST_IDLE;
        else if (xfer_s) next_state_s = ST_DAT;
        else             next_state_s = ST_HDR;
      end
      ST_DAT: begin
        if (abort_s)     next_state_s = ST_IDLE;
        else if (xfer_s) next_state_s = ST_TRL;
        else             next_state_s = ST_DAT;
      end
      ST_TRL: begin
        if (abort_s)     next_state_s = ST_IDLE;
        else if (xfer_s) next_state_s = ST_IDLE;
        else             next_state_s = ST_TRL;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase

    // A starting frame consumes the flag, but events in the same cycle still count
    if (start_s) begin
      pending_s = expire_s | send_req_i;
    end else begin
      pending_s = pending_r | expire_s | send_req_i | abort_s | on_change_s;
    end

    case (next_state_s)
      ST_HDR: begin
        tx_data_s  = {g_HEADER, seq_r};
        tx_valid_s = 1'b1;
      end
      ST_DAT: begin
        tx_data_s  = led_hold_r;
        tx_valid_s = 1'b1;
      end
      ST_TRL: begin
        tx_data_s  = {ck_s, ~ck_s};
        tx_valid_s = 1'b1;
      end
      default: begin
        tx_data_s  = 16'h0000;
        tx_valid_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      pending_r      <= 1'b1;
      period_cnt_r   <= CNT_RELOAD;
      led_hold_r     <= 16'h0000;
      seq_r          <= 8'h00;
      frames_sent_r  <= 16'h0000;
      tx_data_r      <= 16'h0000;
      tx_valid_r     <= 1'b0;
      frame_active_r <= 1'b0;
    end else begin
      state_r        <= next_state_s;
      pending_r      <= pending_s;
      period_cnt_r   <= expire_s ? CNT_RELOAD : (period_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1});
      led_hold_r     <= led_hold_s;
      seq_r          <= done_s ? (seq_r + 8'd1) : seq_r;
      frames_sent_r  <= done_s ? (frames_sent_r + 16'd1) : frames_sent_r;
      tx_data_r      <= tx_data_s;
      tx_valid_r     <= tx_valid_s;
      frame_active_r <= (next_state_s != ST_IDLE);
    end
  end

  assign tx_data_o      = tx_data_r;
  assign tx_valid_o     = tx_valid_r;
  assign frame_active_o = frame_active_r;
  assign seq_o          = seq_r;
  assign frames_sent_o  = frames_sent_r;

endmodule

// File: tb/tb_led_sync_tx.sv
// Directed self-checking bench for led_sync_tx (g_PERIOD=16); the on-change
// scenario runs on a second instance when LED_SYNC_TX_ON_CHANGE_EN is defined.
module tb_led_sync_tx;

  localparam logic [7:0] HDR = 8'hA5;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_i;
  logic        gbt_link_ready;
  logic        send_req_i;
  logic [15:0] led_i;
  logic        tx_ready_i;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        frame_active;
  logic [7:0]  seq;
  logic [15:0] frames_sent;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  led_sync_tx #(.g_PERIOD(32'd16), .g_HEADER(HDR)) dut (
    .clock(clock), .reset(reset), .enable_i(enable_i),
    .gbt_link_ready(gbt_link_ready), .send_req_i(send_req_i),
    .led_i(led_i), .tx_ready_i(tx_ready_i), .tx_data_o(tx_data),
    .tx_valid_o(tx_valid), .frame_active_o(frame_active),
    .seq_o(seq), .frames_sent_o(frames_sent)
  );

`ifdef LED_SYNC_TX_ON_CHANGE_EN
  logic [15:0] tx_data2;
  logic        tx_valid2;
  logic        frame_active2;
  logic [7:0]  seq2;
  logic [15:0] frames_sent2;

  led_sync_tx #(.g_PERIOD(32'd1000), .g_HEADER(HDR)) dut2 (
    .clock(clock), .reset(reset), .enable_i(enable_i),
    .gbt_link_ready(gbt_link_ready), .send_req_i(send_req_i),
    .led_i(led_i), .tx_ready_i(tx_ready_i), .tx_data_o(tx_data2),
    .tx_valid_o(tx_valid2), .frame_active_o(frame_active2),
    .seq_o(seq2), .frames_sent_o(frames_sent2)
  );
`endif

  function automatic logic [15:0] trl_word(input logic [7:0] s, input logic [15:0] led);
    logic [7:0] ck;
    ck = HDR ^ s ^ led[15:8] ^ led[7:0];
    return {ck, ~ck};
  endfunction

  // Opens the enable window until a header appears; returns at that negedge
  task automatic start_frame(output bit ok);
    ok = 1'b0;
    enable_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (tx_valid) begin
        ok = 1'b1;
        break;
      end
    end
    enable_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_checks++;
    if ({tx_data, tx_valid, frame_active, seq, frames_sent} !== 41'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h valid=%b act=%b seq=%h cnt=%h, expected all 0",
               tx_data, tx_valid, frame_active, seq, frames_sent);
    end
  endtask

  task automatic test_basic_frame();
    reset = 1'b0;
    @(negedge clock);
    enable_i = 1'b0;
    n_checks++;
    if (tx_valid !== 1'b1 || frame_active !== 1'b1 || tx_data !== {HDR, 8'h00}) begin
      n_fail++;
      $display("FAIL basic_hdr: got valid=%b act=%b data=%h, expected 1 1 a500", tx_valid, frame_active, tx_data);
    end
    @(negedge clock);
    n_checks++;
    if (tx_data !== 16'h1234) begin
      n_fail++;
      $display("FAIL basic_dat: got %h expected 1234", tx_data);
    end
    @(negedge clock);
    n_checks++;
    if (tx_data !== trl_word(8'h00, 16'h1234) || tx_data !== 16'h837C) begin
      n_fail++;
      $display("FAIL basic_trl: got %h expected %h", tx_data, trl_word(8'h00, 16'h1234));
    end
    @(negedge clock);
    n_checks++;
    if (seq !== 8'd1 || frames_sent !== 16'd1 || tx_valid !== 1'b0 || frame_active !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_end: got seq=%0d cnt=%0d valid=%b act=%b, expected 1 1 0 0",
               seq, frames_sent, tx_valid, frame_active);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    led_i = 16'h4321;
    start_frame(ok);
    n_checks++;
    if (!ok || tx_data !== {HDR, 8'h01}) begin
      n_fail++;
      $display("FAIL bp_hdr: got ok=%b data=%h expected a501", ok, tx_data);
    end
    @(negedge clock);
    tx_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== 16'h4321) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h expected 1 4321", i, tx_valid, tx_data);
      end
    end
    tx_ready_i = 1'b1;
    @(negedge clock);
    n_checks++;
    if (tx_data !== trl_word(8'h01, 16'h4321)) begin
      n_fail++;
      $display("FAIL bp_trl: got %h expected %h", tx_data, trl_word(8'h01, 16'h4321));
    end
    @(negedge clock);
    n_checks++;
    if (seq !== 8'd2 || frames_sent !== 16'd2) begin
      n_fail++;
      $display("FAIL bp_end: got seq=%0d cnt=%0d expected 2 2", seq, frames_sent);
    end
  endtask

  task automatic test_link_drop();
    bit ok;
    led_i = 16'h5A5A;
    start_frame(ok);
    @(negedge clock);
    @(negedge clock);
    gbt_link_ready = 1'b0;
    @(negedge clock);
    n_checks++;
    if (tx_valid !== 1'b0 || frame_active !== 1'b0 || seq !== 8'd2 || frames_sent !== 16'd2) begin
      n_fail++;
      $display("FAIL drop_abort: got valid=%b act=%b seq=%0d cnt=%0d expected 0 0 2 2",
               tx_valid, frame_active, seq, frames_sent);
    end
    repeat (3) @(negedge clock);
    gbt_link_ready = 1'b1;
    start_frame(ok);
    n_checks++;
    if (!ok || tx_data !== {HDR, 8'h02}) begin
      n_fail++;
      $display("FAIL drop_resend: got ok=%b data=%h expected a502", ok, tx_data);
    end
    repeat (3) @(negedge clock);
    n_checks++;
    if (seq !== 8'd3 || frames_sent !== 16'd3) begin
      n_fail++;
      $display("FAIL drop_end: got seq=%0d cnt=%0d expected 3 3", seq, frames_sent);
    end
  endtask

  task automatic test_led_snapshot();
    bit ok;
    led_i = 16'h00FF;
    start_frame(ok);
    led_i = 16'hFF00;
    @(negedge clock);
    n_checks++;
    if (!ok || tx_data !== 16'h00FF) begin
      n_fail++;
      $display("FAIL snap_dat: got ok=%b data=%h expected 00ff", ok, tx_data);
    end
    @(negedge clock);
    n_checks++;
    if (tx_data !== trl_word(8'h03, 16'h00FF)) begin
      n_fail++;
      $display("FAIL snap_trl: got %h expected %h", tx_data, trl_word(8'h03, 16'h00FF));
    end
    @(negedge clock);
    n_checks++;
    if (seq !== 8'd4 || frames_sent !== 16'd4) begin
      n_fail++;
      $display("FAIL snap_end: got seq=%0d cnt=%0d expected 4 4", seq, frames_sent);
    end
  endtask

  task automatic test_enable_gate();
    int  n_valid;
    int  n_hdr;
    bit  seen;
    logic prev;
    enable_i = 1'b0;
    n_valid = 0;
    repeat (100) begin
      @(negedge clock);
      if (tx_valid) n_valid++;
    end
    n_checks++;
    if (n_valid != 0 || frames_sent !== 16'd4) begin
      n_fail++;
      $display("FAIL gate_idle: got valid_cycles=%0d cnt=%0d expected 0 4", n_valid, frames_sent);
    end
    enable_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      if (tx_valid && !seen) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL gate_immediate: got no header, expected header within 2 cycles");
    end
    repeat (3) @(negedge clock);
    n_checks++;
    if (frames_sent !== 16'd5) begin
      n_fail++;
      $display("FAIL gate_one_frame: got cnt=%0d expected 5", frames_sent);
    end
    repeat (20) @(negedge clock);
    prev = tx_valid;
    n_hdr = 0;
    repeat (64) begin
      @(negedge clock);
      if (tx_valid && !prev) n_hdr++;
      prev = tx_valid;
    end
    n_checks++;
    if (n_hdr != 4) begin
      n_fail++;
      $display("FAIL gate_cadence: got %0d frames in 64 cycles, expected 4", n_hdr);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    start_frame(ok);
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (!ok || {tx_data, tx_valid, frame_active, seq, frames_sent} !== 41'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got ok=%b data=%h valid=%b act=%b seq=%h cnt=%h, expected all 0",
               ok, tx_data, tx_valid, frame_active, seq, frames_sent);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

`ifdef LED_SYNC_TX_ON_CHANGE_EN
  task automatic test_on_change();
    int  n_hdr;
    bit  seen;
    logic prev;
    reset = 1'b1;
    led_i = 16'h0001;
    enable_i = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    n_checks++;
    if (frames_sent2 !== 16'd1 || tx_valid2 !== 1'b0) begin
      n_fail++;
      $display("FAIL chg_first: got cnt=%0d valid=%b expected 1 0", frames_sent2, tx_valid2);
    end
    led_i = 16'h0003;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      if (tx_valid2 && !seen) seen = 1'b1;
    end
    n_checks++;
    if (!seen || tx_data2 !== {HDR, 8'h01}) begin
      n_fail++;
      $display("FAIL chg_trigger: got seen=%b data=%h expected 1 a501", seen, tx_data2);
    end
    @(negedge clock);
    n_checks++;
    if (tx_data2 !== 16'h0003) begin
      n_fail++;
      $display("FAIL chg_dat: got %h expected 0003", tx_data2);
    end
    repeat (2) @(negedge clock);
    prev = tx_valid2;
    n_hdr = 0;
    repeat (100) begin
      @(negedge clock);
      if (tx_valid2 && !prev) n_hdr++;
      prev = tx_valid2;
    end
    n_checks++;
    if (n_hdr != 0 || frames_sent2 !== 16'd2) begin
      n_fail++;
      $display("FAIL chg_steady: got extra=%0d cnt=%0d expected 0 2", n_hdr, frames_sent2);
    end
    enable_i = 1'b0;
  endtask
`endif

  initial begin
    reset          = 1'b1;
    enable_i       = 1'b1;
    gbt_link_ready = 1'b1;
    send_req_i     = 1'b0;
    tx_ready_i     = 1'b1;
    led_i          = 16'h1234;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_link_drop();
    test_led_snapshot();
    test_enable_gate();
    test_reset_mid_frame();
`ifdef LED_SYNC_TX_ON_CHANGE_EN
    test_on_change();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
